ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite single-port SRAM slave sitting directly downstream of the core's AHB master glue logic.
- Serves both instruction fetches (hprot[0]=0) and data loads/stores (hprot[0]=1).
- Returns hrdata/hreadyout/hresp, which the master consumes as hr_data/hready/hresp.
- Supports programmable wait states, byte/half/word accesses with byte-lane writes, alignment/range error responses, and write-to-read forwarding.

Parameters:
- DEPTH_LOG2, 10, word-address bits; array holds 2**DEPTH_LOG2 32-bit words.
- WAIT_STATES, 1, extra data-phase cycles with hreadyout=0 per OKAY transfer (0..15).
- RO_WORDS, 256, words at the bottom of the array treated as code region (used only by the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- hsel  in  1  slave select from decoder
- haddr  in  32  byte address; bits [DEPTH_LOG2+1:2] index the array, bits [31:DEPTH_LOG2+2] ignored
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1=write
- hsize  in  3  000 byte, 001 half, 010 word
- hprot  in  4  protection; bit0 distinguishes fetch (0) from data (1)
- hwdata  in  32  write data, valid in data phase
- hready_in  in  1  bus-level hready (address phase accepted when high)
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR
- hrdata  out  32  read data, full word, little-endian lanes

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, all captured address-phase registers cleared. Array contents are not cleared. Reset mid-transfer abandons it: a pending write is not committed.
- Address phase accept: hsel & hready_in & htrans[1]. SEQ is treated as NONSEQ. On accept, capture haddr, hwrite, hsize, hprot.
- IDLE/BUSY with hsel=1, or hsel=0: no transfer, next data phase is zero-wait OKAY.
- Error checks at accept:
  - hsize>010 → error.
  - hsize=001 with haddr[0]=1 → error.
  - hsize=010 with haddr[1:0]≠0 → error.
- States:
  - IDLE: on accept of a legal transfer with WAIT_STATES=0 → DATA; with WAIT_STATES>0 → WAIT, counter=WAIT_STATES. On accept of an illegal transfer → ERR1.
  - WAIT: hreadyout=0; decrement counter; at counter=1 → DATA.
  - DATA: hreadyout=1, hresp=0; transfer completes this cycle. A new accept here follows the IDLE rules (back-to-back pipelining); otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1; a new accept is honoured as in IDLE; otherwise → IDLE. Errored writes never modify the array.
- Write: byte enables from captured hsize/haddr[1:0]:
  - byte → lane haddr[1:0]
  - half → lanes {haddr[1],0} and {haddr[1],1}
  - word → all lanes
  - hwdata is sampled and committed on the rising edge ending the DATA cycle.
- Read: hrdata register loaded with the full array word on the edge entering DATA; hrdata is held until the next read completes. The master selects lanes and sign-extends.
- Forwarding: if a read enters DATA on the same edge a write commits to the same word index, hrdata gets the merged word (written lanes from hwdata, others from the array). No stale data is ever returned.
- Latency: an OKAY transfer occupies 1+WAIT_STATES data-phase cycles; an ERROR transfer occupies exactly 2.

Optional Feature:
- Macro: AHB_SRAM_WRITE_PROTECT_EN.
- Defined: a write whose word index is < RO_WORDS is illegal → ERR1/ERR2 sequence, array unchanged. Reads and fetches are unaffected.
- Undefined: the whole array is writable; RO_WORDS is ignored.

Test Plan:
- WAIT_STATES=1, write word 0xDEADBEEF to 0xB0000010 then read it back → write data phase hreadyout 0,1; read returns 0xDEADBEEF after 2 data cycles, hresp=0.
- Byte write 0x5A at 0xB0000013 over 0x11223344 → read word returns 0x5A223344. Half write 0xABCD at 0xB0000012 → 0xABCD3344.
- Half access at 0xB0000011 → hreadyout/hresp 0/1 then 1/1; subsequent word read shows array unchanged.
- WAIT_STATES=0, back-to-back write 0xCAFEF00D then read at 0xB0000020 → read returns 0xCAFEF00D (forwarding); IDLE htrans with hsel=1 gives zero-wait OKAY.
- Assert reset_n low during a write's WAIT cycle → hreadyout=1, hresp=0, hrdata=0 immediately; read of that address returns the old contents.
- With AHB_SRAM_WRITE_PROTECT_EN, RO_WORDS=256, write to byte address 0x3FC → ERROR, word unchanged; write to 0x400 → OKAY and committed.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the master glue logic and the SRAM slave.
// The slave modport takes the address/data-phase inputs and returns ready/response/read data.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    // Handshake: an address phase is taken when hsel & hready_in & htrans[1] are all high at a
    // rising edge; the data phase ends on the first edge that sees hreadyout high. hwdata must be
    // held for the whole data phase, and hrdata/hresp are valid in the cycle where hreadyout is high.
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready_in,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready_in,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave: wait states, byte-lane writes, error responses, write-to-read forwarding.
// Optional: define AHB_SRAM_WRITE_PROTECT_EN to make the lowest RO_WORDS words read-only.
module ahb_sram_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    ahb_sram_slave_if.slave     bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [DEPTH_LOG2-1:0]  cap_idx;
    logic [1:0]             cap_lane;
    logic                   cap_write;
    logic [2:0]             cap_size;
    logic [3:0]             cap_prot;
    logic                   rdy_q;
    logic                   resp_q;
    logic [31:0]            rdata_q;

    logic [31:0]            mem [2**DEPTH_LOG2];

    logic                   accept;
    logic [DEPTH_LOG2-1:0]  a_idx;
    logic                   size_err;
    logic                   prot_err;
    logic                   a_err;
    logic                   commit;
    logic [3:0]             cap_be;
    logic [31:0]            merged;
    logic [31:0]            rd_word;
    logic                   unused_bits;

    assign accept = bus.hsel & bus.hready_in & bus.htrans[1];
    assign a_idx  = bus.haddr[DEPTH_LOG2+1:2];

    assign size_err = (bus.hsize > 3'd2)
                    | ((bus.hsize == 3'd1) & bus.haddr[0])
                    | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'd0));

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    assign prot_err = bus.hwrite & ({{(32-DEPTH_LOG2){1'b0}}, a_idx} < 32'(RO_WORDS));
`else
    assign prot_err = 1'b0;
`endif

    assign a_err  = size_err | prot_err;
    assign commit = (state == S_DATA) & cap_write;

    always_comb begin
        cap_be = 4'b1111;
        case (cap_size)
            3'd0:    cap_be = 4'b0001 << cap_lane;
            3'd1:    cap_be = cap_lane[1] ? 4'b1100 : 4'b0011;
            default: cap_be = 4'b1111;
        endcase
    end

    // Word as it will look after this cycle's write; also the forwarding source for a colliding read.
    always_comb begin
        merged = mem[cap_idx];
        for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) merged[i*8 +: 8] = bus.hwdata[i*8 +: 8];
        end
    end

    assign rd_word = (commit && (cap_idx == a_idx)) ? merged : mem[a_idx];

    always_ff @(posedge clk) begin
        if (commit) mem[cap_idx] <= merged;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            cap_idx   <= '0;
            cap_lane  <= 2'd0;
            cap_write <= 1'b0;
            cap_size  <= 3'd0;
            cap_prot  <= 4'd0;
            rdy_q     <= 1'b1;
            resp_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state  <= S_DATA;
                        rdy_q  <= 1'b1;
                        resp_q <= 1'b0;
                        // No write can commit while in WAIT, so the array word is current.
                        if (!cap_write) rdata_q <= mem[cap_idx];
                    end
                end
                S_ERR1: begin
                    state  <= S_ERR2;
                    rdy_q  <= 1'b1;
                    resp_q <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        cap_idx   <= a_idx;
                        cap_lane  <= bus.haddr[1:0];
                        cap_write <= bus.hwrite;
                        cap_size  <= bus.hsize;
                        cap_prot  <= bus.hprot;
                        if (a_err) begin
                            state  <= S_ERR1;
                            rdy_q  <= 1'b0;
                            resp_q <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state  <= S_DATA;
                            rdy_q  <= 1'b1;
                            resp_q <= 1'b0;
                            if (!bus.hwrite) rdata_q <= rd_word;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES);
                            rdy_q    <= 1'b0;
                            resp_q   <= 1'b0;
                        end
                    end else begin
                        state  <= S_IDLE;
                        rdy_q  <= 1'b1;
                        resp_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.hreadyout = rdy_q;
    assign bus.hresp     = resp_q;
    assign bus.hrdata    = rdata_q;
    assign dbg_state     = state;

    // Upper address bits are ignored by design; hprot is captured for observability only.
    assign unused_bits = ^{bus.haddr[31:DEPTH_LOG2+2], cap_prot, 32'(RO_WORDS)};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: one instance with WAIT_STATES=1, one with WAIT_STATES=0,
// a reference memory model and an expected-result queue checked when each data phase completes.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ahb_sram_slave_if bus_a();
  ahb_sram_slave_if bus_b();
  logic [2:0] dbg_a, dbg_b;

  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  assign bus_a.hsel      = hsel & ~sel;
  assign bus_a.haddr     = haddr;
  assign bus_a.htrans    = htrans;
  assign bus_a.hwrite    = hwrite;
  assign bus_a.hsize     = hsize;
  assign bus_a.hprot     = hprot;
  assign bus_a.hwdata    = hwdata;
  assign bus_a.hready_in = bus_a.hreadyout;
  assign bus_b.hsel      = hsel & sel;
  assign bus_b.haddr     = haddr;
  assign bus_b.htrans    = htrans;
  assign bus_b.hwrite    = hwrite;
  assign bus_b.hsize     = hsize;
  assign bus_b.hprot     = hprot;
  assign bus_b.hwdata    = hwdata;
  assign bus_b.hready_in = bus_b.hreadyout;

  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1), .RO_WORDS(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a));
  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0), .RO_WORDS(256)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b));

  wire        hready = sel ? bus_b.hreadyout : bus_a.hreadyout;
  wire        hresp  = sel ? bus_b.hresp     : bus_a.hresp;
  wire [31:0] hrdata = sel ? bus_b.hrdata    : bus_a.hrdata;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  bit          mon_en = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      3'd0: r[int'(a)*8 +: 8] = d[int'(a)*8 +: 8];
      3'd1: if (a[1]) r[31:16] = d[31:16]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit protected_word(input bit s, input int idx, input bit wr);
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    return wr && s && (idx < 256);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: one step per cycle of the head transfer's data phase.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      cyc++;
      if (!hready) begin
        check({exp_q[0].tag, "_wresp"}, 32'(hresp), 32'(exp_q[0].err));
      end else begin
        check({exp_q[0].tag, "_lat"}, cyc, exp_q[0].lat);
        check({exp_q[0].tag, "_resp"}, 32'(hresp), 32'(exp_q[0].err));
        if (exp_q[0].rd) check({exp_q[0].tag, "_data"}, hrdata, exp_q[0].data);
        void'(exp_q.pop_front());
        cyc = 0;
      end
    end
  end

  task automatic wait_accept(input string tag);
    bit rdy;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      rdy = hready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input string tag);
    exp_t e;
    int   idx;
    idx    = int'(a[11:2]);
    hsel   = 1'b1;
    htrans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    hprot  = {3'b000, wr ? 1'b1 : 1'($urandom_range(0, 1))};
    wait_accept(tag);
    hwdata = d;
    e.tag  = tag;
    e.err  = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0)
             || protected_word(sel, idx, wr);
    e.lat  = e.err ? 2 : (sel ? 1 : 2);
    e.rd   = !wr && !e.err && model.exists(idx);
    e.data = e.rd ? model[idx] : 32'd0;
    if (wr && !e.err) model[idx] = merge(model.exists(idx) ? model[idx] : 32'd0, d, sz, a[1:0]);
    exp_q.push_back(e);
  endtask

  task automatic idle_xfer(input string tag);
    exp_t e;
    hsel   = 1'b1;
    htrans = 2'b00;
    wait_accept(tag);
    e.tag  = tag;
    e.err  = 1'b0;
    e.rd   = 1'b0;
    e.data = 32'd0;
    e.lat  = 1;
    exp_q.push_back(e);
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic drain();
    int n;
    idle_bus();
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    sel = 1'b0; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hprot = 4'd0; hwdata = 32'd0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_a", 32'(bus_a.hreadyout), 32'd1);
    check("rst_resp_a", 32'(bus_a.hresp), 32'd0);
    check("rst_rdata_a", bus_a.hrdata, 32'd0);
    check("rst_state_a", 32'(dbg_a), 32'd0);
    check("rst_rdy_b", 32'(bus_b.hreadyout), 32'd1);
    check("rst_resp_b", 32'(bus_b.hresp), 32'd0);
    check("rst_rdata_b", bus_b.hrdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // One wait state: word write and read-back.
    issue(1'b1, 32'hB000_0010, 3'd2, 32'hDEAD_BEEF, "w_word");
    issue(1'b0, 32'hB000_0010, 3'd2, 32'd0, "r_word");
    drain();

    // Byte and half writes, merged into an existing word.
    issue(1'b1, 32'hB000_0010, 3'd2, 32'h1122_3344, "w_base");
    issue(1'b1, 32'hB000_0013, 3'd0, {4{8'h5A}}, "w_byte");
    issue(1'b0, 32'hB000_0010, 3'd2, 32'd0, "r_byte");
    issue(1'b1, 32'hB000_0012, 3'd1, {2{16'hABCD}}, "w_half");
    issue(1'b0, 32'hB000_0010, 3'd2, 32'd0, "r_half");
    drain();

    // Alignment and size errors; the array must be untouched.
    issue(1'b1, 32'hB000_0011, 3'd1, 32'hFFFF_FFFF, "e_half_wr");
    issue(1'b0, 32'hB000_0011, 3'd1, 32'd0, "e_half_rd");
    issue(1'b1, 32'hB000_0010, 3'd3, 32'hFFFF_FFFF, "e_size");
    issue(1'b1, 32'hB000_0012, 3'd2, 32'hFFFF_FFFF, "e_word");
    issue(1'b0, 32'hB000_0010, 3'd2, 32'd0, "r_after_err");
    idle_xfer("idle_a");
    drain();

    // Randomised traffic over a small preloaded window.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 32'hB000_0800 + 32'(i * 4), 3'd2, $urandom, "w_init");
    for (int i = 0; i < 30; i++) begin
      logic [2:0] sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 3));
      a  = 32'hB000_0800 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz >= 3'd2) begin sz = 3'd2; a[1:0] = 2'b00; end
      end
      issue(1'($urandom_range(0, 1)), a, sz, $urandom, "rnd");
    end
    drain();

    // Reset during a write's wait cycle abandons the write.
    issue(1'b1, 32'hB000_0040, 3'd2, 32'h0102_0304, "w_pre");
    issue(1'b0, 32'hB000_0040, 3'd2, 32'd0, "r_pre");
    drain();
    mon_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'hB000_0040; hsize = 3'd2; hprot = 4'd1;
    @(posedge clk);
    #1;
    hwdata = 32'hFFFF_FFFF;
    idle_bus();
    @(negedge clk);
    check("rst_wait_rdy", 32'(bus_a.hreadyout), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_rdy", 32'(bus_a.hreadyout), 32'd1);
    check("rst_mid_resp", 32'(bus_a.hresp), 32'd0);
    check("rst_mid_rdata", bus_a.hrdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(1'b0, 32'hB000_0040, 3'd2, 32'd0, "r_post_rst");
    drain();

    // Zero wait states: back-to-back write then read forwards the new data.
    sel = 1'b1;
    issue(1'b1, 32'hB000_0020, 3'd2, 32'hCAFE_F00D, "w_fwd");
    issue(1'b0, 32'hB000_0020, 3'd2, 32'd0, "r_fwd");
    issue(1'b1, 32'hB000_0820, 3'd2, 32'h0123_4567, "w_fwd2");
    issue(1'b1, 32'hB000_0821, 3'd0, {4{8'h77}}, "w_fwd_byte");
    issue(1'b0, 32'hB000_0820, 3'd2, 32'd0, "r_fwd_byte");
    issue(1'b1, 32'hB000_0822, 3'd1, {2{16'h9ABC}}, "w_fwd_half");
    issue(1'b0, 32'hB000_0822, 3'd1, 32'd0, "r_fwd_half");
    idle_xfer("idle_b");
    issue(1'b1, 32'hB000_0011, 3'd1, 32'h0, "e_half_b");
    issue(1'b0, 32'hB000_0820, 3'd2, 32'd0, "r_after_err_b");
    drain();

    // Code-region boundary (protected only when the write-protect build is selected).
    issue(1'b1, 32'h0000_03FC, 3'd2, 32'h55AA_55AA, "w_ro");
    issue(1'b1, 32'h0000_0400, 3'd2, 32'h1234_5678, "w_rw");
    issue(1'b0, 32'h0000_03FC, 3'd2, 32'd0, "r_ro");
    issue(1'b0, 32'h0000_0400, 3'd2, 32'd0, "r_rw");
    issue(1'b0, 32'h0000_0020, 3'd2, 32'd0, "r_fetch");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
